// File: rtl/conf_mul_ctrl_pkg.sv
// Shared state codes, default timing parameters and helpers for the
// configurable-multiplier sequencer.
package conf_mul_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_WARM  = 3'b001;
  localparam logic [2:0] ST_LOW   = 3'b010;
  localparam logic [2:0] ST_HIGH  = 3'b011;
  localparam logic [2:0] ST_DRAIN = 3'b100;
  localparam logic [2:0] ST_RESP  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_WARM  = ST_WARM,
    S_LOW   = ST_LOW,
    S_HIGH  = ST_HIGH,
    S_DRAIN = ST_DRAIN,
    S_RESP  = ST_RESP
  } ctrl_state_e;

  localparam int DEF_WARM_CYCLES = 64;
  localparam int DEF_RES_LAT     = 3;

  function automatic int calc_latency(input int warm_cycles, input int res_lat);
    return warm_cycles + res_lat + 4;
  endfunction

  localparam int LATENCY = calc_latency(DEF_WARM_CYCLES, DEF_RES_LAT);

  // Codes 110/111 never come out of a healthy wrapper.
  function automatic logic code_legal(input logic [2:0] code);
    return code <= ST_RESP;
  endfunction

endpackage

// File: rtl/conf_mul_seq_ctrl_if.sv
// Operand and result handshakes between the kernel datapath (master) and the
// multiplier sequencer (slave).
interface conf_mul_seq_ctrl_if #(
  parameter int DPB = 24
);
  logic           op_valid;
  logic           op_ready;
  logic [DPB-1:0] op_a;
  logic [DPB-12:0] op_b;
  logic           apx_mode;
  logic           res_valid;
  logic           res_ready;
  logic [31:0]    res_p;

  modport master (
    output op_valid, op_a, op_b, apx_mode, res_ready,
    input  op_ready, res_valid, res_p
  );

  modport slave (
    input  op_valid, op_a, op_b, apx_mode, res_ready,
    output op_ready, res_valid, res_p
  );
endinterface

// File: rtl/conf_mul_warm_counter.sv
// Warm-up cycle counter driving the wrapper's count0 input; holds its value
// unless cleared or enabled, and flags when it sits on the terminal count.
module conf_mul_warm_counter #(
  parameter int TERM = 63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [8:0] count,
  output logic       term
);

  localparam logic [8:0] TERM_CODE = 9'(TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 9'd1;
    end
  end

  assign term = (count == TERM_CODE);

endmodule

// File: rtl/conf_mul_seq_ctrl.sv
// Sequencer stepping the configurable accurate/approximate multiplier wrapper
// through warm-up, low/high phases and drain, then returning the captured product.
//
//   state | meaning
//   IDLE  | wrapper product register held clear, waiting for an operand pair
//   WARM  | count0 advances while the wrapper reports WARM, until terminal
//   LOW   | wrapper processes the low half of the shifted operands
//   HIGH  | wrapper processes the high half; drain counter cleared
//   DRAIN | wait RES_LAT cycles for P to settle, capture on the last one
//   RESP  | hold res_p/res_valid until the consumer takes it
module conf_mul_seq_ctrl
  import conf_mul_ctrl_pkg::*;
#(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 24,
  parameter int WARM_CYCLES        = DEF_WARM_CYCLES,
  parameter int RES_LAT            = DEF_RES_LAT
) (
  input  logic                          clk,
  input  logic                          rstN,
  conf_mul_seq_ctrl_if.slave            bus,
  output logic [DATA_PATH_BITWIDTH-1:0]  A_to_mul,
  output logic [DATA_PATH_BITWIDTH-12:0] B_to_mul,
  output logic [2:0]                    state_to_mul,
  input  logic [2:0]                    state_from_mul,
  output logic [8:0]                    count0,
  input  logic [31:0]                   P_from_mul,
  output logic                          racc,
  output logic                          rapx,
  output logic                          rstP,
  output logic                          acc__sel
);

  localparam int DPB = DATA_PATH_BITWIDTH;
  localparam int DW  = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RES_LAT - 1);

  if (OP_BITWIDTH < 1 || WARM_CYCLES < 1 || WARM_CYCLES > 512 || RES_LAT < 1) begin : g_bad_params
    $error("conf_mul_seq_ctrl: unsupported parameter set");
  end

  ctrl_state_e     state_q, state_d;
  logic            racc_q, racc_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [DPB-1:0]  a_q;
  logic [DPB-12:0] b_q;
  logic            apx_q;
  logic [31:0]     res_p_q;
  logic            res_valid_q;

  logic accept, capture, done, illegal;
  logic warm_clr, warm_en, warm_term;

  conf_mul_warm_counter #(
    .TERM (WARM_CYCLES - 1)
  ) u_warm_counter (
    .clk   (clk),
    .rst_n (rstN),
    .clr   (warm_clr),
    .en    (warm_en),
    .count (count0),
    .term  (warm_term)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      racc_q  <= 1'b1;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      racc_q  <= racc_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    racc_d   = 1'b0;
    drain_d  = drain_q;
    accept   = 1'b0;
    capture  = 1'b0;
    done     = 1'b0;
    illegal  = !code_legal(state_from_mul);
    warm_clr = 1'b0;
    warm_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.op_valid && bus.op_ready) begin
          accept   = 1'b1;
          warm_clr = 1'b1;
          state_d  = S_WARM;
        end
      end
      S_WARM: begin
        // The wrapper's own WARM report gates counting, so its echo delay is tolerated.
        if (state_from_mul == ST_WARM) begin
          if (warm_term) state_d = S_LOW;
          else           warm_en = 1'b1;
        end
      end
      S_LOW:  state_d = S_HIGH;
      S_HIGH: begin
        drain_d = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_RESP: begin
        if (bus.res_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      state_d  = S_IDLE;
      racc_d   = 1'b1;
      warm_clr = 1'b1;
      warm_en  = 1'b0;
      accept   = 1'b0;
      capture  = 1'b0;
      done     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_q         <= '0;
      b_q         <= '0;
      apx_q       <= 1'b0;
      res_p_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.op_a;
        b_q   <= bus.op_b;
        apx_q <= bus.apx_mode;
      end
      if (capture) begin
        res_p_q     <= P_from_mul;
        res_valid_q <= 1'b1;
      end else if (done || illegal) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.op_ready  = (state_q == S_IDLE) && !racc_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_p     = res_p_q;

  assign A_to_mul     = a_q;
  assign B_to_mul     = b_q;
  assign state_to_mul = state_q;
  assign racc         = racc_q;
  assign rapx         = apx_q;
  assign acc__sel     = ~apx_q;
  assign rstP         = (state_q == S_IDLE);

endmodule
